ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 device-to-host receiver that turns the raw keyboard `ps2_clk`/`ps2_dat` pin pair into validated scan-code bytes. It sits directly upstream of the keycode recognizer. Its `key_en`/`key_data` outputs are the byte-strobe pair the recognizer consumes. It synchronizes and deglitches the asynchronous PS/2 clock and frames 11-bit packets (start, 8 data LSB-first, odd parity, stop). It also aborts stalled frames with a watchdog.

## Interface

Parameters:
- `SYNC_STAGES`, 2, flip-flop depth of the input synchronizers on both pins (≥2).
- `FILTER_LEN`, 8, consecutive equal synchronized `ps2_clk` samples required before the filtered clock changes level.
- `TIMEOUT_CYC`, 100000, idle clock cycles allowed between PS/2 falling edges inside a frame (2 ms at 50 MHz).

Ports:
- `clk` in 1: system clock; all state is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_dat` in 1: raw PS/2 data pin, asynchronous.
- `key_en` out 1: one-cycle strobe; a valid byte is on `key_data`.
- `key_data` out 8: last valid received byte; held until the next valid byte.
- `frame_err` out 1: one-cycle strobe on a rejected or aborted frame.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation

- Reset values: `key_en`=0, `key_data`=8'h00, `frame_err`=0, `busy`=0, state IDLE, filtered clock=1, synchronizers=1, bit counter=0, watchdog=0.
- Front end: both pins pass through `SYNC_STAGES` flops.
- Glitch filter: the filtered clock takes a new level only after `FILTER_LEN` consecutive synchronized samples at that level.
- Edge detect: a falling edge of the filtered clock is a one-cycle `fall` pulse. The synchronized data bit is sampled in that cycle.
- States:
  - IDLE: on `fall` with data=0, go to DATA and clear the counter. On `fall` with data=1, stay in IDLE with no error (spurious edge).
  - DATA: on each `fall`, shift the bit into bit [7] of the shift register (LSB first). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is valid when the stop bit=1 and the XOR of the 8 data bits and the parity bit is 1.
    - Valid: load `key_data` and pulse `key_en` on the next clock edge.
    - Invalid: pulse `frame_err` and leave `key_data` unchanged.
    - Either way, return to IDLE.
- Watchdog:
  - Counts cycles while state ≠ IDLE and clears on every `fall`.
  - When it reaches `TIMEOUT_CYC`−1: pulse `frame_err`, discard the partial byte, go to IDLE.
  - If a `fall` lands in the same cycle as the timeout, the `fall` wins and the counter clears.
- `key_en` and `frame_err` are never high in the same cycle.
- A frame boundary ends in IDLE, so back-to-back frames need no gap cycles beyond the PS/2 line timing.
- Reset asserted mid-frame clears everything asynchronously. No strobe is emitted for the partial frame.

## Timing

- Pin-to-strobe latency is fixed: L = `SYNC_STAGES` + `FILTER_LEN` + 1 cycles.
  - Measured from the first `clk` edge that samples the stop-bit falling edge at `ps2_clk`.
  - Ends at the cycle `key_en` is high.
  - Default L = 11.
- `key_data` changes in the same cycle `key_en` rises.
- `frame_err` has the same latency as `key_en` for parity and stop errors.
- A timeout `frame_err` fires exactly `TIMEOUT_CYC` cycles after the last `fall`.
- Pulses shorter than `FILTER_LEN` cycles on `ps2_clk` produce no `fall`.
- `ps2_dat` must be stable within ±`FILTER_LEN` cycles of the clock edge. The PS/2 electrical spec guarantees ≥5 µs.

## Configuration

- `PS2_PARITY_CHECK_EN`:
  - Defined: the odd-parity check is enforced as above.
  - Undefined: the parity bit is captured but ignored. Only a bad stop bit or a timeout raises `frame_err`.

## Structure

- Package `ps2_pkg`: state enum (IDLE, DATA, PARITY, STOP), `PS2_DATA_BITS`=8, scan-code constants `PS2_BREAK`=8'hF0 and `PS2_EXT`=8'hE0, shared with the recognizer.
- Sub-module `ps2_clk_filter`: synchronizers, glitch filter and falling-edge detect. Outputs `fall` and the synchronized data bit.
- The FSM, shift register, parity and watchdog live in `ps2_rx`.

## Test plan

- Send byte 8'h1C with correct odd parity (parity bit 0) and stop=1 → one `key_en` exactly L cycles after the stop edge, `key_data`=8'h1C, `frame_err` stays 0.
- Send 8'h1C with parity bit 1:
  - With `PS2_PARITY_CHECK_EN` defined → `frame_err` pulse, `key_data` keeps its previous value, no `key_en`.
  - With the macro undefined → `key_en` fires with 8'h1C.
- Send the sequence 8'hE0, 8'hF0, 8'h75 back-to-back → three `key_en` pulses carrying those values in order.
- Send 4 data bits, then hold `ps2_clk` high → `frame_err` exactly `TIMEOUT_CYC` cycles after the last edge, `busy` drops. A following clean 8'h29 frame is received correctly.
- Inject 3-cycle low glitches on `ps2_clk` while idle and mid-frame → no state change; the frame still decodes correctly.
- Assert `reset_n`=0 after the 5th data bit → all outputs return to reset values immediately, with no strobe. The next full frame decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame geometry and the
// scan-code prefixes the keycode recognizer keys off.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

   localparam int         PS2_DATA_BITS = 8;
   localparam logic [7:0] PS2_BREAK     = 8'hF0;
   localparam logic [7:0] PS2_EXT       = 8'hE0;

   // Odd parity holds when data plus parity bit carry an odd number of ones.
   function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pin front end: synchronizers on both pins, a level filter on the clock
// and a registered falling-edge pulse of the filtered clock.
module ps2_clk_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic fall_o,
   output logic dat_o
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   filt_prev_q;
   logic                   fall_q;
   logic                   clk_s;

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign dat_o  = dat_sync_q[SYNC_STAGES-1];
   assign fall_o = fall_q;

   // The filtered level flips only on the FILTER_LEN-th consecutive differing sample.
   always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (clk_s == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
         filt_d = clk_s;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q  <= '1;
         dat_sync_q  <= '1;
         cnt_q       <= '0;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         fall_q      <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
         cnt_q       <= cnt_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         fall_q      <= filt_prev_q & ~filt_q;
      end
   end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver with frame watchdog.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       key_en,
   output logic [7:0] key_data,
   output logic       frame_err,
   output logic       busy
);

   localparam int             WW      = $clog2(TIMEOUT_CYC + 1);
   localparam int             CNT_W   = $clog2(PS2_DATA_BITS);
   localparam logic [WW-1:0]  WD_LAST = WW'(TIMEOUT_CYC - 1);

   ps2_state_e                state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [PS2_DATA_BITS-1:0]  shift_q;
   logic [PS2_DATA_BITS-1:0]  key_data_q;
   logic                      par_q;
   logic                      key_en_q;
   logic                      frame_err_q;
   logic [WW-1:0]             wd_q;
   logic                      fall;
   logic                      dat;
   logic                      frame_ok;
   logic                      timeout;

   ps2_clk_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_filter (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk_i (ps2_clk),
      .ps2_dat_i (ps2_dat),
      .fall_o    (fall),
      .dat_o     (dat)
   );

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = dat & ps2_odd_parity_ok(shift_q, par_q);
`else
   logic unused_par;
   assign unused_par = par_q;
   assign frame_ok   = dat;
`endif

   // A falling edge in the timeout cycle takes precedence over the abort.
   assign timeout = (state_q != IDLE) && !fall && (wd_q == WD_LAST);

   assign key_en    = key_en_q;
   assign key_data  = key_data_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         key_data_q  <= '0;
         par_q       <= 1'b0;
         key_en_q    <= 1'b0;
         frame_err_q <= 1'b0;
         wd_q        <= '0;
      end else begin
         key_en_q    <= 1'b0;
         frame_err_q <= 1'b0;

         if (state_q == IDLE || fall) begin
            wd_q <= '0;
         end else if (wd_q != WD_LAST) begin
            wd_q <= wd_q + WW'(1);
         end

         case (state_q)
            IDLE: begin
               if (fall && !dat) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
               end
            end
            DATA: begin
               if (fall) begin
                  shift_q <= {dat, shift_q[PS2_DATA_BITS-1:1]};
                  cnt_q   <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(PS2_DATA_BITS - 1)) begin
                     state_q <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (fall) begin
                  par_q   <= dat;
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (fall) begin
                  if (frame_ok) begin
                     key_en_q   <= 1'b1;
                     key_data_q <= shift_q;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (timeout) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed and randomized frames against a frame-level model of the PS/2
// receiver; strobe timing is measured in clk edges from the stop-bit pin edge.
module tb_ps2_rx;
   import ps2_pkg::*;

   localparam int SYNC = 2;
   localparam int FILT = 8;
   localparam int TO   = 400;
   localparam int L    = SYNC + FILT + 1;
   localparam int HALF = 40;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       key_en;
   logic [7:0] key_data;
   logic       frame_err;
   logic       busy;

   ps2_rx #(
      .SYNC_STAGES (SYNC),
      .FILTER_LEN  (FILT),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk   (ps2_clk),
      .ps2_dat   (ps2_dat),
      .key_en    (key_en),
      .key_data  (key_data),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         ken_t[$];
   logic [7:0] ken_d[$];
   int         err_t[$];
   int         both_cnt = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (key_en) begin
            ken_t.push_back(cyc);
            ken_d.push_back(key_data);
         end
         if (frame_err) err_t.push_back(cyc);
         if (key_en && frame_err) both_cnt++;
      end
   end

   int         tests = 0;
   int         fails = 0;
   int         last_fall = 0;
   logic [7:0] held = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_events();
      ken_t.delete();
      ken_d.delete();
      err_t.delete();
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      ps2_dat = b;
      if (glitch) begin
         tick(5);
         ps2_clk = 1'b0;
         tick(3);
         ps2_clk = 1'b1;
         tick(12);
      end else begin
         tick(20);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc + 1;
      tick(HALF);
      ps2_clk = 1'b1;
      tick(20);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                             input int nbits, input int glitch_bit);
      logic [10:0] bits;
      bits = {stp, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_bit);
      ps2_dat = 1'b1;
   endtask

   function automatic logic model_ok(input logic [7:0] b, input logic par, input logic stp);
      int ones;
      ones = int'(par);
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
`ifdef PS2_PARITY_CHECK_EN
      return stp && (ones % 2 == 1);
`else
      return stp && (ones >= 0);
`endif
   endfunction

   function automatic logic odd_par(input logic [7:0] b);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return (ones % 2 == 0);
   endfunction

   task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                            input logic stp, input int glitch_bit);
      clear_events();
      send_frame(b, par, stp, 11, glitch_bit);
      tick(5);
      if (model_ok(b, par, stp)) begin
         check({tag, ".ken_n"}, ken_t.size(), 1);
         check({tag, ".err_n"}, err_t.size(), 0);
         check({tag, ".ken_t"}, ken_t.size() > 0 ? ken_t[0] : -1, last_fall + L);
         check({tag, ".data"}, ken_d.size() > 0 ? ken_d[0] : 8'hxx, b);
         held = b;
      end else begin
         check({tag, ".ken_n"}, ken_t.size(), 0);
         check({tag, ".err_n"}, err_t.size(), 1);
         check({tag, ".err_t"}, err_t.size() > 0 ? err_t[0] : -1, last_fall + L);
      end
      check({tag, ".held"}, key_data, held);
      check({tag, ".busy"}, busy, 1'b0);
   endtask

   initial begin
      logic [7:0] b;
      logic       p, s;
      int         g;

      // Reset state
      tick(3);
      check("rst.key_en", key_en, 1'b0);
      check("rst.key_data", key_data, 8'h00);
      check("rst.frame_err", frame_err, 1'b0);
      check("rst.busy", busy, 1'b0);
      reset_n = 1'b1;
      tick(5);

      run_frame("f1c_good", 8'h1C, 1'b0, 1'b1, -1);
      run_frame("f1c_badpar", 8'h1C, 1'b1, 1'b1, -1);
      run_frame("fE0", PS2_EXT, odd_par(PS2_EXT), 1'b1, -1);
      run_frame("fF0", PS2_BREAK, odd_par(PS2_BREAK), 1'b1, -1);
      run_frame("f75", 8'h75, odd_par(8'h75), 1'b1, -1);
      run_frame("fbadstop", 8'h5A, odd_par(8'h5A), 1'b0, -1);

      // Watchdog: start bit plus 4 data bits, then the line stalls high
      clear_events();
      send_frame(8'hA5, 1'b0, 1'b1, 5, -1);
      check("to.busy_mid", busy, 1'b1);
      tick(TO + L);
      check("to.err_n", err_t.size(), 1);
      check("to.err_t", err_t.size() > 0 ? err_t[0] : -1, last_fall + L + TO);
      check("to.ken_n", ken_t.size(), 0);
      check("to.busy", busy, 1'b0);
      check("to.held", key_data, held);
      run_frame("f29", 8'h29, odd_par(8'h29), 1'b1, -1);

      // Short low glitch while idle
      clear_events();
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(30);
      check("glitch_idle.busy", busy, 1'b0);
      check("glitch_idle.events", ken_t.size() + err_t.size(), 0);
      run_frame("glitch_mid", 8'h3B, odd_par(8'h3B), 1'b1, 4);

      // Reset after the 5th data bit
      clear_events();
      send_frame(8'hC3, odd_par(8'hC3), 1'b1, 6, -1);
      check("rstmid.busy_before", busy, 1'b1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("rstmid.key_en", key_en, 1'b0);
      check("rstmid.key_data", key_data, 8'h00);
      check("rstmid.frame_err", frame_err, 1'b0);
      check("rstmid.busy", busy, 1'b0);
      tick(3);
      reset_n = 1'b1;
      held    = 8'h00;
      tick(20);
      check("rstmid.events", ken_t.size() + err_t.size(), 0);
      run_frame("after_rst", 8'h4E, odd_par(8'h4E), 1'b1, -1);

      // Randomized frames: mostly good, some parity or stop errors, some glitches
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom_range(0, 255));
         p = odd_par(b);
         s = 1'b1;
         case ($urandom_range(0, 5))
            0: p = ~p;
            1: s = 1'b0;
            default: ;
         endcase
         g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
         run_frame($sformatf("rnd%0d", i), b, p, s, g);
      end

      check("never_both", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
